// File: rtl/fsm_pulse_period_checker.sv
// Receive-side monitor for a periodic one-hot pulse stream.
// Hunts for a reference pulse, verifies LOCK_CNT good periods before locking,
// then flags and counts period violations until UNLOCK_ERRS consecutive
// violations drop it back to hunting.
module fsm_pulse_period_checker #(
  parameter int PERIOD      = 3,
  parameter int LOCK_CNT    = 4,
  parameter int UNLOCK_ERRS = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_in,
  input  logic             clr_count,
  output logic             lock,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  localparam int PH_W   = $clog2(PERIOD);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_ERRS + 1);

  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(PERIOD - 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(UNLOCK_ERRS - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t            state;
  logic [PH_W-1:0]   phase;
  logic [GOOD_W-1:0] good;
  logic [MISS_W-1:0] miss;

  logic              expect_pulse;
  logic              violation;
  logic [PH_W-1:0]   phase_adv;
  logic [CNT_W-1:0]  cnt_inc;

  // A pulse belongs exactly at phase 0; anything else is a violation.
  // Phase codes past PERIOD-1 (non power-of-two PERIOD) fold back to 0.
  always_comb begin
    expect_pulse = (phase == '0);
    violation    = (pulse_in != expect_pulse);
    phase_adv    = (phase >= PH_LAST) ? '0 : phase + PH_W'(1);
    cnt_inc      = (&err_count) ? err_count : err_count + CNT_W'(1);
  end

  // Checker FSM with phase tracking, registered lock/err outputs and
  // the saturating violation counter (clear has priority over increment).
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HUNT;
      phase     <= '0;
      good      <= '0;
      miss      <= '0;
      lock      <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      phase     <= phase_adv;

      case (state)
        HUNT: begin
          // Any pulse becomes the reference; the next expected one is PERIOD later.
          if (pulse_in) begin
            phase <= PH_W'(1);
            good  <= '0;
            state <= VERIFY;
          end
        end

        VERIFY: begin
          // A bad period aborts silently; the offending pulse is discarded.
          if (violation) begin
            state <= HUNT;
          end else if (expect_pulse) begin
            good <= good + GOOD_W'(1);
            if (good == GOOD_LAST) begin
              state <= LOCKED;
              lock  <= 1'b1;
              miss  <= '0;
            end
          end
        end

        LOCKED: begin
          // Phase free-runs here: neither a miss nor an extra pulse re-phases it.
          if (violation) begin
            err_pulse <= 1'b1;
            miss      <= miss + MISS_W'(1);
            if (miss == MISS_LAST) begin
              state <= HUNT;
              lock  <= 1'b0;
            end
          end else if (expect_pulse) begin
            miss <= '0;
          end
        end

        default: begin
          state <= HUNT;
          lock  <= 1'b0;
        end
      endcase

      if (clr_count) begin
        err_count <= '0;
      end else if (state == LOCKED && violation) begin
        err_count <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_fsm_pulse_period_checker.sv
// Bench for fsm_pulse_period_checker: one task per scenario, expected
// outputs queued when a cycle is driven and popped after its clock edge.
// A second instance with CNT_W=2 runs on the same stimulus for saturation.
module tb_fsm_pulse_period_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pulse_in = 1'b0;
  logic        clr_count = 1'b0;
  logic        lock, err_pulse;
  logic [15:0] err_count;
  logic        lock2, err_pulse2;
  logic [1:0]  err_count2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic lock;
    logic ep;
    int   cnt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  fsm_pulse_period_checker #(
    .PERIOD(3), .LOCK_CNT(4), .UNLOCK_ERRS(2), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .pulse_in(pulse_in), .clr_count(clr_count),
    .lock(lock), .err_pulse(err_pulse), .err_count(err_count)
  );

  fsm_pulse_period_checker #(
    .PERIOD(3), .LOCK_CNT(4), .UNLOCK_ERRS(2), .CNT_W(2)
  ) dut2 (
    .clk(clk), .reset(reset), .pulse_in(pulse_in), .clr_count(clr_count),
    .lock(lock2), .err_pulse(err_pulse2), .err_count(err_count2)
  );

  // Drive one cycle of inputs, queue the outputs expected after its edge.
  task automatic drive(input int k, input logic p, input logic c, input logic r,
                       input logic el, input logic ep, input int cnt);
    exp_t e;
    e.lock = el;
    e.ep   = ep;
    e.cnt  = cnt;
    pulse_in  = p;
    clr_count = c;
    reset     = r;
    sb.push_back(e);
    @(posedge clk);
    #1;
    $display("k=%0d rst=%b pulse=%b clr=%b -> lock=%b err_pulse=%b err_count=%0d | w2: %b %b %0d",
             k, r, p, c, lock, err_pulse, err_count, lock2, err_pulse2, err_count2);
  endtask

  task automatic test_reset();
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      drive(k, logic'(k % 2), logic'(k == 2), 1'b1, 1'b0, 1'b0, 0);
      e = sb.pop_front();
      checks++;
      if (lock !== e.lock || err_pulse !== e.ep || err_count !== 16'(e.cnt)) begin
        errors++;
        $display("FAIL reset k=%0d got lock=%b err_pulse=%b err_count=%0d expected %b %b %0d",
                 k, lock, err_pulse, err_count, e.lock, e.ep, e.cnt);
      end
    end
  endtask

  // Reset, then reference at 5 and good pulses at 8,11,14,17: lock after edge 17.
  task automatic test_lock_acquire();
    exp_t e;
    logic p;
    drive(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    e = sb.pop_front();
    checks++;
    if (lock !== e.lock || err_pulse !== e.ep || err_count !== 16'(e.cnt)) begin
      errors++;
      $display("FAIL acquire_reset got lock=%b err_pulse=%b err_count=%0d expected %b %b %0d",
               lock, err_pulse, err_count, e.lock, e.ep, e.cnt);
    end
    for (int k = 1; k <= 17; k++) begin
      p = (k >= 5) && ((k - 5) % 3 == 0);
      drive(k, p, 1'b0, 1'b0, logic'(k == 17), 1'b0, 0);
      e = sb.pop_front();
      checks++;
      if (lock !== e.lock || err_pulse !== e.ep || err_count !== 16'(e.cnt) || lock2 !== e.lock) begin
        errors++;
        $display("FAIL acquire k=%0d got lock=%b err_pulse=%b err_count=%0d lock2=%b expected %b %b %0d",
                 k, lock, err_pulse, err_count, lock2, e.lock, e.ep, e.cnt);
      end
    end
  endtask

  // One missing pulse at a time keeps lock; miss clears on the next good pulse.
  task automatic test_single_miss();
    exp_t e;
    logic p;
    test_lock_acquire();
    for (int k = 18; k <= 35; k++) begin
      p = (k % 3 == 2) && (k != 20) && (k != 32);
      drive(k, p, 1'b0, 1'b0, 1'b1, logic'(k == 20 || k == 32),
            (k < 20) ? 0 : (k < 32) ? 1 : 2);
      e = sb.pop_front();
      checks++;
      if (lock !== e.lock || err_pulse !== e.ep || err_count !== 16'(e.cnt)) begin
        errors++;
        $display("FAIL single_miss k=%0d got lock=%b err_pulse=%b err_count=%0d expected %b %b %0d",
                 k, lock, err_pulse, err_count, e.lock, e.ep, e.cnt);
      end
    end
  endtask

  // Two consecutive misses unlock; pulse at 25 is a new reference, relock after 37.
  task automatic test_double_miss();
    exp_t e;
    logic p;
    test_lock_acquire();
    for (int k = 18; k <= 38; k++) begin
      p = (k >= 25) && (k <= 37) && ((k - 25) % 3 == 0);
      drive(k, p, 1'b0, 1'b0, logic'(k < 23 || k >= 37), logic'(k == 20 || k == 23),
            (k < 20) ? 0 : (k < 23) ? 1 : 2);
      e = sb.pop_front();
      checks++;
      if (lock !== e.lock || err_pulse !== e.ep || err_count !== 16'(e.cnt)) begin
        errors++;
        $display("FAIL double_miss k=%0d got lock=%b err_pulse=%b err_count=%0d expected %b %b %0d",
                 k, lock, err_pulse, err_count, e.lock, e.ep, e.cnt);
      end
    end
  endtask

  // Extra pulse at 29 during VERIFY aborts without counting and is not reused:
  // reference at 32, lock after 44 (reuse would lock after 41).
  task automatic test_verify_extra();
    exp_t e;
    logic p;
    test_lock_acquire();
    for (int k = 18; k <= 45; k++) begin
      p = (k == 25) || (k == 28) || (k == 29) || ((k >= 32) && (k <= 44) && ((k - 32) % 3 == 0));
      drive(k, p, 1'b0, 1'b0, logic'(k < 23 || k >= 44), logic'(k == 20 || k == 23),
            (k < 20) ? 0 : (k < 23) ? 1 : 2);
      e = sb.pop_front();
      checks++;
      if (lock !== e.lock || err_pulse !== e.ep || err_count !== 16'(e.cnt)) begin
        errors++;
        $display("FAIL verify_extra k=%0d got lock=%b err_pulse=%b err_count=%0d expected %b %b %0d",
                 k, lock, err_pulse, err_count, e.lock, e.ep, e.cnt);
      end
    end
  endtask

  // Build err_count=5 while locked, reset on a would-be violation, then relock from HUNT.
  task automatic test_reset_locked();
    exp_t e;
    logic p;
    logic om;
    for (int k = 0; k < 1; k++) test_lock_acquire();
    for (int k = 18; k <= 64; k++) begin
      om = (k >= 20) && (k <= 44) && ((k - 20) % 6 == 0);
      if (k <= 49) begin
        p = (k % 3 == 2) && !om;
        drive(k, p, 1'b0, 1'b0, 1'b1, om,
              (k < 20) ? 0 : (((k > 44) ? 44 : k) - 20) / 6 + 1);
      end else if (k == 50) begin
        drive(k, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      end else begin
        p = (k <= 63) && ((k - 51) % 3 == 0);
        drive(k, p, 1'b0, 1'b0, logic'(k >= 63), 1'b0, 0);
      end
      e = sb.pop_front();
      checks++;
      if (lock !== e.lock || err_pulse !== e.ep || err_count !== 16'(e.cnt)) begin
        errors++;
        $display("FAIL reset_locked k=%0d got lock=%b err_pulse=%b err_count=%0d expected %b %b %0d",
                 k, lock, err_pulse, err_count, e.lock, e.ep, e.cnt);
      end
    end
  endtask

  // Five violations saturate the 2-bit counter at 3; clear wins over a same-cycle violation.
  task automatic test_saturate_clear();
    exp_t e;
    logic p;
    logic om;
    int   cnt;
    test_lock_acquire();
    for (int k = 18; k <= 59; k++) begin
      om = ((k >= 20) && (k <= 44) && ((k - 20) % 6 == 0)) || (k == 50) || (k == 56);
      p  = (k % 3 == 2) && !om;
      if (k < 20)       cnt = 0;
      else if (k < 50)  cnt = (((k > 44) ? 44 : k) - 20) / 6 + 1;
      else if (k < 56)  cnt = 0;
      else              cnt = 1;
      drive(k, p, logic'(k == 50), 1'b0, 1'b1, om, cnt);
      e = sb.pop_front();
      checks++;
      if (lock !== e.lock || err_pulse !== e.ep || err_count !== 16'(e.cnt)) begin
        errors++;
        $display("FAIL saturate_w16 k=%0d got lock=%b err_pulse=%b err_count=%0d expected %b %b %0d",
                 k, lock, err_pulse, err_count, e.lock, e.ep, e.cnt);
      end
      checks++;
      if (lock2 !== e.lock || err_pulse2 !== e.ep || err_count2 !== 2'((e.cnt > 3) ? 3 : e.cnt)) begin
        errors++;
        $display("FAIL saturate_w2 k=%0d got lock=%b err_pulse=%b err_count=%0d expected %b %b %0d",
                 k, lock2, err_pulse2, err_count2, e.lock, e.ep, (e.cnt > 3) ? 3 : e.cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_acquire();
    test_single_miss();
    test_double_miss();
    test_verify_extra();
    test_reset_locked();
    test_saturate_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
